cheri_lsu_arb: RTL

Two-master arbiter between the core load/store path and the stack-zeroization engine in front of the single 33-bit data bus. Issued transactions keep their owner in an ownership FIFO so that in-order responses return to the requester that issued them. Address-phase requests follow the OBI rule: a request is held stable until granted. The CPU has priority, bounded by a starvation counter so that zeroization always makes progress.

---
 rtl/cheri_pkg.sv | 31 +++
 rtl/cheri_own_fifo.sv | 61 ++++++
 rtl/cheri_lsu_arb.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/cheri_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cheri_pkg: shared types for the LSU data-bus arbiter and its FIFO.   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package cheri_pkg;

  localparam int unsigned BUS_AW = 32;
  localparam int unsigned BUS_DW = 33;

  typedef enum logic {
    OWN_CPU  = 1'b0,
    OWN_STKZ = 1'b1
  } arb_owner_e;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_LOCK_CPU  = 2'd1,
    ARB_LOCK_STKZ = 2'd2
  } arb_state_e;

  // Address-phase fields of one master, packed in bus order.
  typedef struct packed {
    logic              we;
    logic              is_cap;
    logic [BUS_AW-1:0] addr;
    logic [BUS_DW-1:0] wdata;
  } arb_req_t;

endpackage
`default_nettype wire

// File: rtl/cheri_own_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cheri_own_fifo: 1-bit-wide ownership FIFO, push/pop in one cycle.   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module cheri_own_fifo #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] mem;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign head    = mem[rd_ptr];
  // A pop frees the slot first, so a full FIFO still accepts a same-cycle push.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= bump(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= bump(rd_ptr);
      end
      if (do_push != do_pop) begin
        count <= do_push ? count + 1'b1 : count - 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cheri_lsu_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cheri_lsu_arb: CPU / stack-zeroizer arbiter onto the 33-bit data bus |
// | with in-order response steering. Revision: 1.0                        |
// +----------------------------------------------------------------------+
module cheri_lsu_arb
  import cheri_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned StarveLimit    = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic        cpu_is_cap_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [32:0] cpu_wdata_i,
  output logic        cpu_gnt_o,
  output logic        cpu_rvalid_o,
  output logic        cpu_err_o,
  output logic [32:0] cpu_rdata_o,
  input  logic        stkz_req_i,
  input  logic        stkz_we_i,
  input  logic        stkz_is_cap_i,
  input  logic [31:0] stkz_addr_i,
  input  logic [32:0] stkz_wdata_i,
  output logic        stkz_req_done_o,
  output logic        stkz_rvalid_o,
  output logic        stkz_err_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic        data_is_cap_o,
  output logic [31:0] data_addr_o,
  output logic [32:0] data_wdata_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic        data_err_i,
  input  logic [32:0] data_rdata_i
);

  localparam int unsigned SCW = $clog2(StarveLimit + 1);

  localparam logic [1:0] ST_IDLE      = 2'(ARB_IDLE);
  localparam logic [1:0] ST_LOCK_CPU  = 2'(ARB_LOCK_CPU);
  localparam logic [1:0] ST_LOCK_STKZ = 2'(ARB_LOCK_STKZ);

  logic [1:0]     state_q;
  logic [1:0]     state_d;
  logic [SCW-1:0] starve_q;
  logic [SCW-1:0] starve_d;
  logic           starved;
  logic           sel_stkz;
  logic           src_req;
  logic           issuable;
  logic           fifo_push;
  logic           fifo_pop;
  logic           fifo_full;
  logic           fifo_empty;
  logic           fifo_head;
  arb_req_t       cpu_bus;
  arb_req_t       stkz_bus;
  arb_req_t       sel_bus;

  assign cpu_bus  = '{we: cpu_we_i, is_cap: cpu_is_cap_i, addr: cpu_addr_i, wdata: cpu_wdata_i};
  assign stkz_bus = '{we: stkz_we_i, is_cap: stkz_is_cap_i, addr: stkz_addr_i, wdata: stkz_wdata_i};
  assign starved  = (starve_q == SCW'(StarveLimit));

  // A presented-but-ungranted request freezes the select until its grant.
  always_comb begin
    sel_stkz = 1'b0;
    unique case (state_q)
      ST_LOCK_CPU:  sel_stkz = 1'b0;
      ST_LOCK_STKZ: sel_stkz = 1'b1;
      default:      sel_stkz = stkz_req_i & (~cpu_req_i | starved);
    endcase
  end

  assign fifo_pop   = data_rvalid_i & ~fifo_empty;
  assign issuable   = ~fifo_full | fifo_pop;
  assign src_req    = sel_stkz ? stkz_req_i : cpu_req_i;
  assign sel_bus    = sel_stkz ? stkz_bus : cpu_bus;

  assign data_req_o = src_req & issuable;
  assign {data_we_o, data_is_cap_o, data_addr_o, data_wdata_o} = data_req_o ? sel_bus : '0;

  assign fifo_push       = data_req_o & data_gnt_i;
  assign cpu_gnt_o       = fifo_push & ~sel_stkz;
  assign stkz_req_done_o = fifo_push & sel_stkz;

  assign cpu_rvalid_o  = fifo_pop & (fifo_head == OWN_CPU);
  assign stkz_rvalid_o = fifo_pop & (fifo_head == OWN_STKZ);
  assign cpu_err_o     = cpu_rvalid_o & data_err_i;
  assign stkz_err_o    = stkz_rvalid_o & data_err_i;
  assign cpu_rdata_o   = data_rdata_i;

  always_comb begin
    state_d = ST_IDLE;
    if (data_req_o && !data_gnt_i) begin
      state_d = sel_stkz ? ST_LOCK_STKZ : ST_LOCK_CPU;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!stkz_req_i || stkz_req_done_o) begin
      starve_d = '0;
    end else if (cpu_gnt_o && !starved) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  cheri_own_fifo #(
    .DEPTH (MaxOutstanding)
  ) u_own_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (fifo_push),
    .din    (sel_stkz),
    .pop    (fifo_pop),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .head   (fifo_head)
  );

`ifndef SYNTHESIS
  // Stray responses are dropped by the pop gating; this only reports them.
  a_no_stray_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    data_rvalid_i |-> !fifo_empty)
    else $warning("cheri_lsu_arb: data_rvalid_i with no outstanding transaction ignored");

  a_cpu_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == ST_LOCK_CPU) |-> (cpu_req_i && $stable(cpu_addr_i)));

  a_stkz_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == ST_LOCK_STKZ) |-> (stkz_req_i && $stable(stkz_addr_i)));

  a_one_grant: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(cpu_gnt_o && stkz_req_done_o));
`endif

endmodule
`default_nettype wire
